// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, ALU codes,
// op1 steering encodings, FSM state type and an opcode legality check.
package ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b001000;
  localparam logic [5:0] ALU_SLL  = 6'b000001;
  localparam logic [5:0] ALU_SLT  = 6'b000010;
  localparam logic [5:0] ALU_SLTU = 6'b000011;
  localparam logic [5:0] ALU_XOR  = 6'b000100;
  localparam logic [5:0] ALU_SRL  = 6'b000101;
  localparam logic [5:0] ALU_SRA  = 6'b001101;
  localparam logic [5:0] ALU_OR   = 6'b000110;
  localparam logic [5:0] ALU_AND  = 6'b000111;
  localparam logic [5:0] ALU_BEQ  = 6'b010000;
  localparam logic [5:0] ALU_BNE  = 6'b010001;
  localparam logic [5:0] ALU_BLT  = 6'b010100;
  localparam logic [5:0] ALU_BGE  = 6'b010101;
  localparam logic [5:0] ALU_BLTU = 6'b010110;
  localparam logic [5:0] ALU_BGEU = 6'b010111;
  localparam logic [5:0] ALU_JAL  = 6'b011111;
  localparam logic [5:0] ALU_JALR = 6'b111111;

  localparam logic [1:0] OP1_RS1  = 2'b00;
  localparam logic [1:0] OP1_PC   = 2'b01;
  localparam logic [1:0] OP1_PC4  = 2'b10;
  localparam logic [1:0] OP1_ZERO = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  // Known opcodes are legal; branches with funct3 010/011 have no meaning.
  function automatic logic is_legal(input logic [6:0] opcode, input logic [2:0] funct3);
    logic ok;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_SYSTEM: ok = 1'b1;
      OPC_BRANCH: ok = (funct3 != 3'b010) && (funct3 != 3'b011);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/imm_generator.sv
// Sign-extended immediate extraction for I/S/B/U/J formats; register-register
// instructions carry no immediate and yield zero.
module imm_generator
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm32
);

  logic [6:0] opcode;

  assign opcode = instr[6:0];

  // Pick the immediate layout from the opcode, I-format when nothing else fits
  always_comb begin
    imm32 = {{20{instr[31]}}, instr[31:20]};
    case (opcode)
      OPC_STORE:          imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:         imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm32 = {instr[31:12], 12'b0};
      OPC_JAL:            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_OP:             imm32 = '0;
      default:            ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing, PC update
// and ALU/memory/writeback steering decoded from the latched instruction.
// Optional feature: define CTRL_TRAP_EN to halt with illegal=1 on illegal
// instructions; otherwise they retire as NOPs.
module mc_controller
  import ctrl_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instruction,
  input  logic            instr_valid,
  input  logic            branch,
  input  logic [PC_W-1:0] jalr_target,
  input  logic            mem_ready,
  output logic [PC_W-1:0] pc,
  output logic            fetch_req,
  output logic [4:0]      read_sel1,
  output logic [4:0]      read_sel2,
  output logic [4:0]      write_sel,
  output logic [31:0]     imm32,
  output logic [5:0]      alu_control,
  output logic [1:0]      op1_sel,
  output logic            op2_sel,
  output logic            branch_op,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            halted,
  output logic            illegal
);

  state_t          state, state_next;
  logic [31:0]     ir;
  logic [PC_W-1:0] pc_q, pc_next, jalr_q, pc_plus4, pc_plus_imm, jalr_dest;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_load, is_store, is_branch, is_jal, is_jalr, is_ecall, legal;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign read_sel1 = ir[19:15];
  assign read_sel2 = ir[24:20];
  assign write_sel = ir[11:7];

  imm_generator u_imm (
    .instr (ir),
    .imm32 (imm32)
  );

  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_ecall  = (opcode == OPC_SYSTEM);
  assign legal     = is_legal(opcode, funct3);

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + PC_W'(4);
  assign pc_plus_imm = pc_q + imm32[PC_W-1:0];
  assign jalr_dest   = jalr_q & ~PC_W'(1);
  assign halted      = (state == S_HALT);

`ifdef CTRL_TRAP_EN
  logic illegal_q, illegal_next;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // ALU and operand steering, a pure function of the instruction register
  always_comb begin
    alu_control = ALU_ADD;
    op1_sel     = OP1_RS1;
    op2_sel     = 1'b0;
    branch_op   = 1'b0;
    mem_to_reg  = 1'b0;
    case (opcode)
      OPC_OP:     alu_control = {2'b00, ir[30], funct3};
      OPC_OP_IMM: begin
        alu_control = {2'b00, (funct3 == 3'b101) & ir[30], funct3};
        op2_sel     = 1'b1;
      end
      OPC_LOAD: begin
        op2_sel    = 1'b1;
        mem_to_reg = 1'b1;
      end
      OPC_STORE:  op2_sel = 1'b1;
      OPC_BRANCH: begin
        alu_control = {3'b010, funct3};
        branch_op   = 1'b1;
      end
      OPC_LUI: begin
        op1_sel = OP1_ZERO;
        op2_sel = 1'b1;
      end
      OPC_AUIPC: begin
        op1_sel = OP1_PC;
        op2_sel = 1'b1;
      end
      OPC_JAL: begin
        alu_control = ALU_JAL;
        op1_sel     = OP1_PC4;
      end
      OPC_JALR: begin
        alu_control = ALU_JALR;
        op1_sel     = OP1_PC4;
        op2_sel     = 1'b1;
      end
      default: ;
    endcase
  end

  // Next state, PC update on the instruction's final state, and strobes
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    fetch_req  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
`ifdef CTRL_TRAP_EN
    illegal_next = illegal_q;
`endif
    case (state)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_ecall) begin
          state_next = S_HALT;
        end else if (!legal) begin
`ifdef CTRL_TRAP_EN
          state_next   = S_HALT;
          illegal_next = 1'b1;
`else
          state_next = S_FETCH;
          pc_next    = pc_plus4;
`endif
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_next = S_MEM;
        end else if (is_branch) begin
          state_next = S_FETCH;
          pc_next    = branch ? pc_plus_imm : pc_plus4;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        mem_read  = is_load;
        mem_write = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_next = S_WB;
          end else begin
            state_next = S_FETCH;
            pc_next    = pc_plus4;
          end
        end
      end
      S_WB: begin
        reg_write  = (write_sel != 5'd0);
        state_next = S_FETCH;
        if (is_jal)       pc_next = pc_plus_imm;
        else if (is_jalr) pc_next = jalr_dest;
        else              pc_next = pc_plus4;
      end
      S_HALT:  ;
      default: state_next = S_FETCH;
    endcase
  end

  // State, PC, instruction and JALR target registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      pc_q   <= RESET_PC;
      ir     <= NOP_INSTR;
      jalr_q <= '0;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
      if (state == S_FETCH && instr_valid) ir <= instruction;
      if (state == S_EXEC) jalr_q <= jalr_target;
    end
  end

`ifdef CTRL_TRAP_EN
  // Sticky trap flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_next;
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: table of instructions run back to back with a
// scoreboard of expected results, plus hand sequences for halt, illegal
// instructions and reset in the middle of a memory wait.
module tb_mc_controller;
  import ctrl_pkg::*;

  localparam int              PC_W     = 16;
  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
  localparam int              NVEC     = 14;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     instruction;
  logic            instr_valid;
  logic            branch;
  logic [PC_W-1:0] jalr_target;
  logic            mem_ready;
  logic [PC_W-1:0] pc;
  logic            fetch_req;
  logic [4:0]      read_sel1, read_sel2, write_sel;
  logic [31:0]     imm32;
  logic [5:0]      alu_control;
  logic [1:0]      op1_sel;
  logic            op2_sel, branch_op, mem_read, mem_write, mem_to_reg, reg_write, halted, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0]     instr;
    logic            br;
    logic [PC_W-1:0] jt;
    int              fd;
    int              md;
    logic [PC_W-1:0] exp_pc;
    int              exp_rw;
    logic [4:0]      exp_ws;
    int              exp_rd;
    int              exp_wr;
    logic [5:0]      exp_alu;
    logic [1:0]      exp_op1;
    logic            exp_op2;
    logic [31:0]     exp_imm;
  } vec_t;

  typedef struct {
    logic [PC_W-1:0] pc;
    int              rw;
    int              rd;
    int              wr;
    logic [4:0]      ws;
    logic [5:0]      alu;
    logic [1:0]      op1;
    logic            op2;
    logic [31:0]     imm;
    int              fetch_drop;
    int              timeout;
  } obs_t;

  vec_t vecs [NVEC];
  vec_t sb [$];

  mc_controller #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .branch      (branch),
    .jalr_target (jalr_target),
    .mem_ready   (mem_ready),
    .pc          (pc),
    .fetch_req   (fetch_req),
    .read_sel1   (read_sel1),
    .read_sel2   (read_sel2),
    .write_sel   (write_sel),
    .imm32       (imm32),
    .alu_control (alu_control),
    .op1_sel     (op1_sel),
    .op2_sel     (op2_sel),
    .branch_op   (branch_op),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .halted      (halted),
    .illegal     (illegal)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Hard stop in case something wedges the sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Runs one instruction starting at a falling edge in FETCH; returns at the
  // falling edge where FETCH is seen again, HALT is reached, or the bound expires
  task automatic runInstr(input logic [31:0] ins, input int fd, input int md, input logic br,
                          input logic [PC_W-1:0] jt, output obs_t o);
    int mc;
    int cyc;
    o = '{default: 0};
    if (!fetch_req) o.fetch_drop++;
    for (int k = 0; k < fd; k++) begin
      instr_valid = 1'b0;
      instruction = $urandom;
      @(negedge clk);
      if (!fetch_req) o.fetch_drop++;
    end
    instruction = ins;
    instr_valid = 1'b1;
    branch      = br;
    jalr_target = jt;
    @(negedge clk);
    instr_valid = 1'b0;
    instruction = $urandom;
    o.ws  = write_sel;
    o.alu = alu_control;
    o.op1 = op1_sel;
    o.op2 = op2_sel;
    o.imm = imm32;
    mc  = 0;
    cyc = 0;
    while (!fetch_req && !halted && cyc < 40) begin
      if (reg_write) o.rw++;
      if (mem_read)  o.rd++;
      if (mem_write) o.wr++;
      if (mem_read || mem_write) begin
        mc++;
        mem_ready = (mc > md);
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    mem_ready = 1'b0;
    o.timeout = (cyc >= 40) ? 1 : 0;
    o.pc      = pc;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    obs_t o;
    vec_t e;
    sb.push_back(v);
    runInstr(v.instr, v.fd, v.md, v.br, v.jt, o);
    e = sb.pop_front();
    checkOutput($sformatf("v%0d_timeout", idx), o.timeout, 0);
    checkOutput($sformatf("v%0d_fetch_req_wait", idx), o.fetch_drop, 0);
    checkOutput($sformatf("v%0d_pc", idx), 32'(o.pc), 32'(e.exp_pc));
    checkOutput($sformatf("v%0d_reg_write_pulses", idx), o.rw, e.exp_rw);
    checkOutput($sformatf("v%0d_write_sel", idx), 32'(o.ws), 32'(e.exp_ws));
    checkOutput($sformatf("v%0d_mem_read_cycles", idx), o.rd, e.exp_rd);
    checkOutput($sformatf("v%0d_mem_write_cycles", idx), o.wr, e.exp_wr);
    checkOutput($sformatf("v%0d_alu_control", idx), 32'(o.alu), 32'(e.exp_alu));
    checkOutput($sformatf("v%0d_op1_sel", idx), 32'(o.op1), 32'(e.exp_op1));
    checkOutput($sformatf("v%0d_op2_sel", idx), 32'(o.op2), 32'(e.exp_op2));
    checkOutput($sformatf("v%0d_imm32", idx), o.imm, e.exp_imm);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    obs_t o;
    int   bad;
    int   cyc;

    //                instr         br    jt        fd md exp_pc    rw ws     rd wr alu        op1    op2   imm
    vecs[0]  = '{32'h00500093, 1'b0, 16'h0000, 3, 0, 16'h0004, 1, 5'd1,  0, 0, 6'b000000, 2'b00, 1'b1, 32'h00000005};
    vecs[1]  = '{32'h0020A423, 1'b0, 16'h0000, 0, 2, 16'h0008, 0, 5'd8,  0, 3, 6'b000000, 2'b00, 1'b1, 32'h00000008};
    vecs[2]  = '{32'h0040A183, 1'b0, 16'h0000, 0, 1, 16'h000C, 1, 5'd3,  2, 0, 6'b000000, 2'b00, 1'b1, 32'h00000004};
    vecs[3]  = '{32'h002081B3, 1'b1, 16'h0000, 0, 0, 16'h0010, 1, 5'd3,  0, 0, 6'b000000, 2'b00, 1'b0, 32'h00000000};
    vecs[4]  = '{32'hFE208CE3, 1'b1, 16'h0000, 0, 0, 16'h0008, 0, 5'd25, 0, 0, 6'b010000, 2'b00, 1'b0, 32'hFFFFFFF8};
    vecs[5]  = '{32'h40208233, 1'b0, 16'h0000, 1, 0, 16'h000C, 1, 5'd4,  0, 0, 6'b001000, 2'b00, 1'b0, 32'h00000000};
    vecs[6]  = '{32'h123452B7, 1'b0, 16'h0000, 0, 0, 16'h0010, 1, 5'd5,  0, 0, 6'b000000, 2'b11, 1'b1, 32'h12345000};
    vecs[7]  = '{32'hFE208CE3, 1'b0, 16'h0000, 0, 0, 16'h0014, 0, 5'd25, 0, 0, 6'b010000, 2'b00, 1'b0, 32'hFFFFFFF8};
    vecs[8]  = '{32'h00001317, 1'b0, 16'h0000, 0, 0, 16'h0018, 1, 5'd6,  0, 0, 6'b000000, 2'b01, 1'b1, 32'h00001000};
    vecs[9]  = '{32'h4030D393, 1'b0, 16'h0000, 2, 0, 16'h001C, 1, 5'd7,  0, 0, 6'b001101, 2'b00, 1'b1, 32'h00000403};
    vecs[10] = '{32'h00000013, 1'b0, 16'h0000, 0, 0, 16'h0020, 0, 5'd0,  0, 0, 6'b000000, 2'b00, 1'b1, 32'h00000000};
    vecs[11] = '{32'h000280E7, 1'b0, 16'h0123, 0, 0, 16'h0122, 1, 5'd1,  0, 0, 6'b111111, 2'b10, 1'b1, 32'h00000000};
    vecs[12] = '{32'h000280E7, 1'b0, 16'hFFFD, 0, 0, 16'hFFFC, 1, 5'd1,  0, 0, 6'b111111, 2'b10, 1'b1, 32'h00000000};
    vecs[13] = '{32'h008000EF, 1'b0, 16'h0000, 0, 0, 16'h0004, 1, 5'd1,  0, 0, 6'b011111, 2'b10, 1'b0, 32'h00000008};

    rst_n       = 1'b0;
    instruction = 32'h0;
    instr_valid = 1'b0;
    branch      = 1'b0;
    jalr_target = '0;
    mem_ready   = 1'b0;

    #12;
    checkOutput("reset_pc", 32'(pc), 32'(RESET_PC));
    checkOutput("reset_fetch_req", 32'(fetch_req), 1);
    checkOutput("reset_halted", 32'(halted), 0);
    checkOutput("reset_illegal", 32'(illegal), 0);
    checkOutput("reset_strobes", {29'd0, mem_read, mem_write, reg_write}, 0);
    checkOutput("reset_ir_nop_alu", 32'(alu_control), 32'(ALU_ADD));
    checkOutput("reset_ir_nop_fields", {imm32[26:0], write_sel}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

    $display("[TB] ECALL sequence");
    runInstr(32'h00000073, 0, 0, 1'b0, '0, o);
    checkOutput("ecall_halted", 32'(halted), 1);
    checkOutput("ecall_fetch_req", 32'(fetch_req), 0);
    checkOutput("ecall_pc", 32'(pc), 32'h0004);
    checkOutput("ecall_reg_write", o.rw, 0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      instr_valid = 1'($urandom_range(0, 1));
      mem_ready   = 1'($urandom_range(0, 1));
      instruction = 32'h00500093;
      @(negedge clk);
      if (!halted || fetch_req || mem_read || mem_write || reg_write || pc != 16'h0004) bad++;
    end
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    checkOutput("halt_hold_violations", bad, 0);

    $display("[TB] illegal opcode sequence");
    doReset();
    runInstr(32'h000000FF, 0, 0, 1'b0, '0, o);
    checkOutput("illegal_reg_write", o.rw, 0);
    checkOutput("illegal_mem_strobes", o.rd + o.wr, 0);
`ifdef CTRL_TRAP_EN
    checkOutput("illegal_halted", 32'(halted), 1);
    checkOutput("illegal_flag", 32'(illegal), 1);
    checkOutput("illegal_fetch_req", 32'(fetch_req), 0);
`else
    checkOutput("illegal_timeout", o.timeout, 0);
    checkOutput("illegal_halted", 32'(halted), 0);
    checkOutput("illegal_flag", 32'(illegal), 0);
    checkOutput("illegal_pc", 32'(pc), 32'h0004);
`endif

    $display("[TB] reset during LW memory wait");
    doReset();
    runInstr(32'h00500093, 0, 0, 1'b0, '0, o);
    checkOutput("pre_lw_pc", 32'(pc), 32'h0004);
    instruction = 32'h0040A183;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    cyc = 0;
    while (!mem_read && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("lw_reached_mem", 32'(mem_read), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midmem_reset_mem_read", 32'(mem_read), 0);
    checkOutput("midmem_reset_pc", 32'(pc), 32'(RESET_PC));
    checkOutput("midmem_reset_fetch_req", 32'(fetch_req), 1);
    checkOutput("midmem_reset_reg_write", 32'(reg_write), 0);
    @(negedge clk);
    rst_n = 1'b1;
    runInstr(32'h00500093, 0, 0, 1'b0, '0, o);
    checkOutput("post_reset_pc", 32'(pc), 32'h0004);
    checkOutput("post_reset_reg_write", o.rw, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter PC_W, default 16, width of program counter and all target buses.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 instruction  input  32  fetched instruction word, sampled when instr_valid=1 in FETCH.
REQ-006 instr_valid  input  1  instruction memory handshake; word valid this cycle.
REQ-007 branch  input  1  ALU branch-taken flag, sampled in EXEC.
REQ-008 jalr_target  input  PC_W  ALU-computed JALR destination, sampled in EXEC.
REQ-009 mem_ready  input  1  data memory handshake; access completes this cycle.
REQ-010 pc  output  PC_W  current instruction address.
REQ-011 fetch_req  output  1  request to instruction memory.
REQ-012 read_sel1 / read_sel2 / write_sel  output  5 each  register indices from latched instruction.
REQ-013 imm32  output  32  immediate of latched instruction.
REQ-014 alu_control  output  6; op1_sel output 2; op2_sel output 1; branch_op output 1  ALU steering.
REQ-015 mem_read / mem_write  output  1 each  data memory strobes.
REQ-016 mem_to_reg  output 1; reg_write  output 1  writeback controls.
REQ-017 halted  output 1  ECALL reached; illegal  output 1  trap flag.

Function
REQ-018 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-019 FETCH: fetch_req=1; wait while instr_valid=0; on instr_valid=1 latch instruction into IR, go DECODE.
REQ-020 DECODE: one cycle; ECALL -> HALT; illegal opcode -> per REQ-034/035; else -> EXEC.
REQ-021 EXEC: one cycle; LOAD/STORE -> MEM; BRANCH -> FETCH; all others -> WB.
REQ-022 MEM: mem_read (LOAD) or mem_write (STORE) held 1 until mem_ready=1; LOAD -> WB, STORE -> FETCH.
REQ-023 WB: reg_write=1 for exactly one cycle, suppressed when write_sel=0; -> FETCH.
REQ-024 reg_write, mem_read, mem_write SHALL be 0 in every state other than those stated.
REQ-025 PC update in the exiting state only: BRANCH taken or JAL -> pc+imm32; JALR -> {jalr_target[PC_W-1:1],1'b0}; else pc+4.
REQ-026 PC arithmetic SHALL be modulo 2^PC_W; wrap from max to 0 without flag.
REQ-027 Decode outputs (sels, imm32, alu_control, op sels, branch_op, mem_to_reg) SHALL derive only from IR, stable DECODE through WB.
REQ-028 ALU codes: add 000000, sub 001000, sll 000001, slt 000010, sltu 000011, xor 000100, srl 000101, sra 001101, or 000110, and 000111; beq 010000, bne 010001, blt 010100, bge 010101, bltu 010110, bgeu 010111; JAL 011111, JALR 111111.
REQ-029 op1_sel: 00 rs1, 01 pc (AUIPC), 10 pc+4 (JAL/JALR), 11 zero (LUI); op2_sel 1 for I-type/LOAD/STORE/AUIPC/LUI.
REQ-030 HALT: halted=1, fetch_req=0, no strobes; remains until reset.
REQ-031 instr_valid or mem_ready asserted outside their waiting state SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately force state FETCH, pc=RESET_PC, IR=32'h00000013 (NOP), halted=0, illegal=0, all strobes 0.
REQ-033 Reset mid-MEM SHALL drop mem_read/mem_write asynchronously; no write completes.

Configuration
REQ-034 With CTRL_TRAP_EN defined: unknown opcode, or unknown funct3 for BRANCH, -> HALT with illegal=1.
REQ-035 Without CTRL_TRAP_EN: illegal instruction SHALL be executed as NOP (pc+4, no writes), illegal tied 0.

Structure
REQ-036 Package ctrl_pkg SHALL hold opcode constants, ALU code constants, op1_sel encodings, FSM state enum.
REQ-037 Immediate decode SHALL be a sub-module imm_generator (I/S/B/U/J formats, sign-extended).

Verification
REQ-038 Reset, instr_valid held 0 three cycles then ADDI x1,x0,5 -> fetch_req high throughout wait; one reg_write pulse, write_sel=1; pc=4.
REQ-039 SW with mem_ready delayed 2 cycles -> mem_write high exactly 3 cycles; reg_write never 1; pc=+4.
REQ-040 BEQ imm=-8 at pc=0x0010, branch=1 -> pc=0x0008; branch=0 -> pc=0x0014.
REQ-041 JALR with jalr_target=0x0123 -> pc=0x0122, op1_sel=10, one reg_write pulse; JAL at pc=0xFFFC, PC_W=16, imm=8 -> pc=0x0004.
REQ-042 ECALL -> halted=1, fetch_req=0 forever; opcode 7'b1111111 -> halted=1, illegal=1 with CTRL_TRAP_EN, pc=+4 and illegal=0 without.
REQ-043 rst_n pulled low during MEM wait of a LW -> mem_read=0 same cycle, pc=RESET_PC, state FETCH.
